// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP      = 2'd1,
        WAIT_MRET = 2'd2,
        ACK       = 2'd3
    } irq_state_e;

    localparam logic [31:0] MCAUSE_INT_BIT = 32'h8000_0000;
    localparam int unsigned IRQ_CAUSE_BASE = 16;
    localparam int unsigned MIE_IRQ_LSB    = 16;

    // Index width for n lines; at least one bit so a single line still has a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational find-first-set over N request bits, starting at start_i and wrapping.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N = 16,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);

    // Scan from start_i upward modulo N; first set bit wins.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_c && req_i[IW'((32'(start_i) + i) % N)]) begin
                valid_c = 1'b1;
                idx_c   = IW'((32'(start_i) + i) % N);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: masks and prioritises device requests,
// raises a trap request with mcause, waits for mret, then acks the device.
// Optional macro IRQ_ROUND_ROBIN_EN: rotate arbitration start after each
// serviced interrupt instead of fixed lowest-index priority.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned IRQ_NUM = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        mie_i,
    input  logic [IRQ_NUM-1:0] int_req_i,
    input  logic               trap_ack_i,
    input  logic               mret_i,
    output logic               int_o,
    output logic [31:0]        mcause_o,
    output logic [IRQ_NUM-1:0] int_rst_o
);

    localparam int unsigned IW = idx_width(IRQ_NUM);
    localparam logic [31:0] MIE_MASK = 32'(((64'd1 << IRQ_NUM) - 64'd1) << MIE_IRQ_LSB);

    irq_state_e         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [31:0]        mcause_q, mcause_d;
    logic               int_q, int_d;
    logic [IRQ_NUM-1:0] int_rst_q, int_rst_d;

    logic [IRQ_NUM-1:0] en_c;
    logic [IW-1:0]      start_c;
    logic [IW-1:0]      arb_idx_c;
    logic               arb_valid_c;
    logic               unused_mie_c;

    // Only the device-interrupt slice of mie gates requests.
    assign en_c         = int_req_i & mie_i[MIE_IRQ_LSB +: IRQ_NUM];
    assign unused_mie_c = |(mie_i & ~MIE_MASK);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IW-1:0] last_q, last_d;

    // Remember the line just acknowledged so the next search starts after it.
    always_comb begin
        last_d = last_q;
        if (state_q == ACK) begin
            last_d = idx_q;
        end
    end

    // Search start is one past the last serviced line, wrapping at IRQ_NUM.
    always_comb begin
        start_c = (last_q == IW'(IRQ_NUM - 1)) ? '0 : last_q + IW'(1);
    end

    // Last-serviced register; reset value makes the first grant fixed-priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= IW'(IRQ_NUM - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign start_c = '0;
`endif

    irq_arbiter #(
        .N (IRQ_NUM)
    ) u_arbiter (
        .req_i   (en_c),
        .start_i (start_c),
        .idx_c   (arb_idx_c),
        .valid_c (arb_valid_c)
    );

    // Next-state and registered-output logic; a latched request is never cancelled.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mcause_d  = mcause_q;
        int_d     = 1'b0;
        int_rst_d = '0;

        case (state_q)
            IDLE: begin
                if (arb_valid_c) begin
                    idx_d    = arb_idx_c;
                    mcause_d = MCAUSE_INT_BIT | (32'(IRQ_CAUSE_BASE) + 32'(arb_idx_c));
                    state_d  = TRAP;
                end
            end
            TRAP: begin
                // trap_ack_i takes precedence; a simultaneous mret_i is not consumed here.
                if (trap_ack_i) begin
                    state_d = WAIT_MRET;
                end
            end
            WAIT_MRET: begin
                if (mret_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        int_d     = (state_d == TRAP);
        int_rst_d = (state_d == ACK) ? (IRQ_NUM'(1) << idx_d) : '0;
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mcause_q  <= '0;
            int_q     <= 1'b0;
            int_rst_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mcause_q  <= mcause_d;
            int_q     <= int_d;
            int_rst_q <= int_rst_d;
        end
    end

    assign int_o     = int_q;
    assign mcause_o  = mcause_q;
    assign int_rst_o = int_rst_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a scoreboard of expected grants.
module tb_irq_controller;

    typedef struct {
        logic [31:0] mcause;
        logic [15:0] ack;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] mie;
    logic [15:0] req;
    logic        trap_ack;
    logic        mret;
    logic        int_o;
    logic [31:0] mcause_o;
    logic [15:0] int_rst_o;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    irq_controller #(
        .IRQ_NUM (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mie_i      (mie),
        .int_req_i  (req),
        .trap_ack_i (trap_ack),
        .mret_i     (mret),
        .int_o      (int_o),
        .mcause_o   (mcause_o),
        .int_rst_o  (int_rst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] mc, input logic [15:0] ack);
        exp_t e;
        e.mcause = mc;
        e.ack    = ack;
        exp_q.push_back(e);
    endtask

    // Wait for a trap request, then run trap_ack / mret and check the acknowledge.
    task automatic service(input logic clear);
        exp_t e;
        int   n;
        n = 0;
        while (int_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("int_o_raise", 32'(int_o), 32'd1);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("mcause_trap", mcause_o, e.mcause);
        chk("int_rst_in_trap", 32'(int_rst_o), 32'd0);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        chk("int_o_wait_mret", 32'(int_o), 32'd0);
        chk("mcause_held", mcause_o, e.mcause);
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("int_rst_ack", 32'(int_rst_o), 32'(e.ack));
        chk("int_o_in_ack", 32'(int_o), 32'd0);
        if (clear) req = req & ~e.ack;
        step();
        chk("int_rst_one_cycle", 32'(int_rst_o), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        mie      = '0;
        req      = '0;
        trap_ack = 1'b0;
        mret     = 1'b0;
        step();
        step();
        chk("rst_int_o", 32'(int_o), 32'd0);
        chk("rst_mcause", mcause_o, 32'd0);
        chk("rst_int_rst", 32'(int_rst_o), 32'd0);
        rst = 1'b0;
        step();

        // Single line 3 with its mie bit set.
        mie = 32'h0008_0000;
        req = 16'h0008;
        push(32'h8000_0013, 16'h0008);
        step();
        chk("latency_int_o", 32'(int_o), 32'd1);
        service(1'b1);

        // Masked request stays silent until mie enables it.
        mie = 32'h0000_0000;
        req = 16'h0008;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("masked_int_o", 32'(int_o), 32'd0);
        end
        mie = 32'h0008_0000;
        push(32'h8000_0013, 16'h0008);
        step();
        chk("unmask_int_o", 32'(int_o), 32'd1);
        service(1'b1);

        // Lines 2 and 5 together; line 3 was serviced last.
        mie = 32'hFFFF_0000;
        req = 16'h0024;
`ifdef IRQ_ROUND_ROBIN_EN
        push(32'h8000_0015, 16'h0020);
        push(32'h8000_0012, 16'h0004);
`else
        push(32'h8000_0012, 16'h0004);
        push(32'h8000_0015, 16'h0020);
`endif
        service(1'b1);
        service(1'b1);

        // mret in IDLE is ignored.
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("mret_idle_int_o", 32'(int_o), 32'd0);
        chk("mret_idle_int_rst", 32'(int_rst_o), 32'd0);

        // mret in TRAP ignored; dropping mie/req does not cancel; ack+mret together.
        mie = 32'h0008_0000;
        req = 16'h0008;
        step();
        chk("trap2_int_o", 32'(int_o), 32'd1);
        req  = 16'h0000;
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("mret_trap_int_o", 32'(int_o), 32'd1);
        chk("mret_trap_int_rst", 32'(int_rst_o), 32'd0);
        mie = 32'h0000_0000;
        step();
        chk("mie_clear_int_o", 32'(int_o), 32'd1);
        chk("mie_clear_mcause", mcause_o, 32'h8000_0013);
        trap_ack = 1'b1;
        mret     = 1'b1;
        step();
        trap_ack = 1'b0;
        mret     = 1'b0;
        chk("ack_mret_int_o", 32'(int_o), 32'd0);
        chk("ack_mret_int_rst", 32'(int_rst_o), 32'd0);
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("late_mret_ack", 32'(int_rst_o), 32'h0000_0008);
        chk("late_mret_mcause", mcause_o, 32'h8000_0013);
        step();
        chk("late_mret_one_cycle", 32'(int_rst_o), 32'd0);

        // Asynchronous reset while waiting for mret.
        mie = 32'h0008_0000;
        req = 16'h0008;
        step();
        chk("pre_rst_int_o", 32'(int_o), 32'd1);
        req      = 16'h0000;
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_int_o", 32'(int_o), 32'd0);
        chk("async_rst_mcause", mcause_o, 32'd0);
        chk("async_rst_int_rst", 32'(int_rst_o), 32'd0);
        rst = 1'b0;
        step();
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("post_rst_mret", 32'(int_rst_o), 32'd0);
        step();
        chk("post_rst_mret2", 32'(int_rst_o), 32'd0);

        // Lines 0 and 1 held continuously.
        mie = 32'hFFFF_0000;
        req = 16'h0003;
`ifdef IRQ_ROUND_ROBIN_EN
        push(32'h8000_0010, 16'h0001);
        push(32'h8000_0011, 16'h0002);
        push(32'h8000_0010, 16'h0001);
        push(32'h8000_0011, 16'h0002);
`else
        push(32'h8000_0010, 16'h0001);
        push(32'h8000_0010, 16'h0001);
        push(32'h8000_0010, 16'h0001);
        push(32'h8000_0010, 16'h0001);
`endif
        for (int i = 0; i < 4; i++) begin
            service(1'b0);
        end
        req = 16'h0000;
        step();
        step();
        chk("final_idle_int_o", 32'(int_o), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Machine-mode interrupt source for the core: masks and prioritises external device requests.
- Presents one trap request plus an mcause value to the core's trap/CSR logic.
- Waits for the handler's mret, then returns a one-cycle acknowledge to the serviced device.
- Sits between peripheral IRQ lines and the core pipeline. It is the initiator side of the trap interface that writes mepc/mcause.

Parameters:
- IRQ_NUM, 16, number of device interrupt lines (1..16); line i maps to mie bit 16+i and cause code 16+i.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- mie_i  input  32  current mie CSR value
- int_req_i  input  IRQ_NUM  level-sensitive device requests
- trap_ack_i  input  1  core has taken the trap (mepc/mcause written this cycle)
- mret_i  input  1  core executing mret this cycle
- int_o  output  1  trap request to core
- mcause_o  output  32  cause value for the pending/serviced interrupt
- int_rst_o  output  IRQ_NUM  one-hot acknowledge to the serviced device

Behaviour:
- Reset (async, rst_i=1): state IDLE; int_o=0; mcause_o=0; int_rst_o=0; latched index=0.
- Effective request: en = int_req_i & mie_i[16 +: IRQ_NUM].
- States:
  - IDLE: if en!=0, latch index = lowest set bit of en; mcause_o <= 32'h8000_0000 | (16+index); go to TRAP. Else stay.
  - TRAP: int_o=1 (Moore, registered state decode). On trap_ack_i go to WAIT_MRET.
  - WAIT_MRET: int_o=0. On mret_i go to ACK.
  - ACK: int_rst_o[index]=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: a request enabled at edge N drives int_o=1 from cycle N+1. Minimum request-to-int_rst_o time is 3 cycles.
- Once a request is latched it is committed, i.e. not cancelled:
  - deasserting int_req_i or clearing the mie bit during TRAP/WAIT_MRET has no effect;
  - mcause_o is held unchanged until the next IDLE latch.
- mret_i is ignored outside WAIT_MRET. trap_ack_i is ignored outside TRAP.
- trap_ack_i and mret_i high in the same cycle while in TRAP: only trap_ack_i acts (goes to WAIT_MRET). mret_i is consumed only from WAIT_MRET.
- No nesting: new requests arriving during TRAP/WAIT_MRET/ACK stay pending (level) and are arbitrated on the first IDLE cycle after ACK.
- Devices must clear their request on the edge where int_rst_o is sampled. A request still held in IDLE is re-serviced (legal, not an error).
- int_rst_o is one-hot or zero at all times. int_o and int_rst_o are never both high.
- mie_i bits outside [16 +: IRQ_NUM] are ignored.
- Reset asserted in any state returns to IDLE immediately. No partial acknowledge pulse is emitted.

Optional Feature:
- Macro IRQ_ROUND_ROBIN_EN.
- Defined: the arbiter searches en starting at (last_serviced_index+1) mod IRQ_NUM, wrapping around. last_serviced_index updates in ACK and resets to IRQ_NUM-1, so the first grant after reset equals fixed priority.
- Undefined: fixed priority, lowest index wins; no last_serviced register is synthesised.

Decomposition:
- Shared package irq_pkg:
  - state enum (IDLE, TRAP, WAIT_MRET, ACK);
  - MCAUSE_INT_BIT = 32'h8000_0000;
  - IRQ_CAUSE_BASE = 16;
  - MIE_IRQ_LSB = 16.
- One sub-module, irq_arbiter: combinational find-first-set over IRQ_NUM bits with a rotate-start input, used by both modes. Outputs the index and a valid flag.

Test Plan:
- int_req_i=0x0008, mie_i=0x0008_0000:
  - int_o=1 next cycle, mcause_o=0x8000_0013;
  - after trap_ack_i then mret_i, int_rst_o=0x0008 for one cycle, then IDLE.
- int_req_i=0x0008, mie_i=0: int_o stays 0 for 20 cycles. Set mie_i=0x0008_0000: int_o=1 next cycle.
- int_req_i=0x0024, mie_i=0xFFFF_0000, fixed priority:
  - first mcause_o=0x8000_0012, int_rst_o=0x0004;
  - then, with line 5 still held, mcause_o=0x8000_0015, int_rst_o=0x0020.
- mret_i pulsed in IDLE and in TRAP: no state change, int_rst_o=0. Clearing mie_i during TRAP: int_o remains 1 until trap_ack_i.
- rst_i pulsed mid-cycle in WAIT_MRET: int_o=0, mcause_o=0, int_rst_o=0 immediately. Subsequent mret_i produces no ack.
- IRQ_ROUND_ROBIN_EN, int_req_i=0x0003 held continuously: grants alternate mcause_o 0x8000_0010, 0x8000_0011, 0x8000_0010, ...
